// File: rtl/acc_window_i8_pkg.sv
// Shared definitions for the i8 window accumulator: FSM state type,
// default widths shared with the upstream muladd stage, and width helpers.
package acc_window_i8_pkg;

   // Default widths shared with the registered multiply-add stage
   localparam int I8_W       = 8;
   localparam int ACC_DEF_W  = 16;
   localparam int WINDOW_DEF = 4;

   // Widest value the sign-extension helper can handle
   localparam int SEXT_MAX_W = 64;

   typedef enum logic [0:0] {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } acc_state_e;

   // Ceiling log2; clog2(1) = 0
   function automatic int clog2(input int value);
      int result;
      int span;
      result = 0;
      span   = 1;
      while (span < value) begin
         span   = span * 2;
         result = result + 1;
      end
      return result;
   endfunction

   // Sample counter width; a window of one still needs a one-bit counter
   function automatic int cnt_width(input int window);
      return (clog2(window) < 1) ? 1 : clog2(window);
   endfunction

   // Sign-extend the low data_w bits of x to SEXT_MAX_W bits.
   // Works for data_w == target width, where a replication would be empty.
   function automatic logic [SEXT_MAX_W-1:0] sext(input logic [SEXT_MAX_W-1:0] x,
                                                   input int data_w);
      logic [SEXT_MAX_W-1:0] result;
      for (int i = 0; i < SEXT_MAX_W; i++) begin
         result[i] = (i < data_w) ? x[i] : x[data_w-1];
      end
      return result;
   endfunction

endpackage

// File: rtl/acc_window_i8_if.sv
// Sample-in / sum-out stream bundle between the muladd stage, the window
// accumulator and its consumer.
interface acc_window_i8_if #(
   parameter int DATA_W = 8,
   parameter int ACC_W  = 16
);
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_ready;
   logic              out_valid;
   logic [ACC_W-1:0]  out_data;
   logic              out_ready;

   // Producer/consumer side: drives samples and the output-ready
   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );

   // Accumulator side
   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/acc_window_i8.sv
// Window accumulator: sums WINDOW consecutive accepted signed samples
// (wrapping modulo 2^ACC_W) and presents each sum until it is taken.
// out_valid is the HOLD state bit, so it comes straight from a flop.
module acc_window_i8
   import acc_window_i8_pkg::*;
#(
   parameter int DATA_W = I8_W,
   parameter int ACC_W  = ACC_DEF_W,
   parameter int WINDOW = WINDOW_DEF
) (
   input  logic clock,
   input  logic reset,
   acc_window_i8_if.slave bus
);

   localparam int             CNT_W    = cnt_width(WINDOW);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WINDOW - 1);

   acc_state_e       r_state;
   acc_state_e       w_state_nxt;
   logic [ACC_W-1:0] r_acc;
   logic [ACC_W-1:0] r_out_data;
   logic [CNT_W-1:0] r_count;
   logic [ACC_W-1:0] w_sample;
   logic [ACC_W-1:0] w_sum;
   logic             w_in_ready;
   logic             w_accept;
   logic             w_take;
   logic             w_last;

   assign w_sample = ACC_W'(sext(SEXT_MAX_W'(bus.in_data), DATA_W));
   assign w_sum    = r_acc + w_sample;

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = (r_state == HOLD);
   assign bus.out_data  = r_out_data;

   // Handshake decode: ready depends only on state, reset and out_ready
   always_comb begin
      w_in_ready = 1'b0;
      w_take     = 1'b0;
      if (reset) begin
         w_in_ready = 1'b0;
         w_take     = 1'b0;
      end else begin
         case (r_state)
            ACCUM: begin
               w_in_ready = 1'b1;
               w_take     = 1'b0;
            end
            HOLD: begin
               w_in_ready = bus.out_ready;
               w_take     = bus.out_ready;
            end
            default: begin
               w_in_ready = 1'b0;
               w_take     = 1'b0;
            end
         endcase
      end
      w_accept = bus.in_valid & w_in_ready;
      w_last   = w_accept & (r_count == LAST_CNT);
   end

   // Next-state: a window completion always (re)enters HOLD, even on a take
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ACCUM: begin
            if (w_last) begin
               w_state_nxt = HOLD;
            end else begin
               w_state_nxt = ACCUM;
            end
         end
         HOLD: begin
            if (w_last) begin
               w_state_nxt = HOLD;
            end else if (w_take) begin
               w_state_nxt = ACCUM;
            end else begin
               w_state_nxt = HOLD;
            end
         end
         default: begin
            w_state_nxt = ACCUM;
         end
      endcase
   end

   // State register
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= ACCUM;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Accumulator, sample counter and output register; only an accepted
   // sample is ever loaded, so idle or invalid data never reaches the sums
   always_ff @(posedge clock) begin
      if (reset) begin
         r_acc      <= {ACC_W{1'b0}};
         r_count    <= {CNT_W{1'b0}};
         r_out_data <= {ACC_W{1'b0}};
      end else if (w_last) begin
         r_out_data <= w_sum;
         r_acc      <= {ACC_W{1'b0}};
         r_count    <= {CNT_W{1'b0}};
      end else if (w_accept) begin
         r_acc      <= w_sum;
         r_count    <= r_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_acc_window_i8.sv
// Bench for acc_window_i8: table-driven vectors, corner-case sequences on
// three builds (default, 8-bit accumulator, single-sample window) and a
// randomized run against a sample-list reference model.
module tb_acc_window_i8;

   localparam int A_WINDOW = 4;

   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;

   acc_window_i8_if #(.DATA_W(8), .ACC_W(16)) if_a ();
   acc_window_i8_if #(.DATA_W(8), .ACC_W(8))  if_b ();
   acc_window_i8_if #(.DATA_W(8), .ACC_W(8))  if_c ();

   acc_window_i8 #(.DATA_W(8), .ACC_W(16), .WINDOW(4)) u_a (.clock(clk), .reset(rst), .bus(if_a));
   acc_window_i8 #(.DATA_W(8), .ACC_W(8),  .WINDOW(4)) u_b (.clock(clk), .reset(rst), .bus(if_b));
   acc_window_i8 #(.DATA_W(8), .ACC_W(8),  .WINDOW(1)) u_c (.clock(clk), .reset(rst), .bus(if_c));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        v;
      logic [7:0]  d;
      logic        rdy;
      logic        exp_irdy;
      logic        exp_ov;
      logic [15:0] exp_od;
   } vec_t;

   vec_t tbl [31];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic drive_a(input logic v, input logic [7:0] d, input logic r);
      @(negedge clk);
      if_a.in_valid  = v;
      if_a.in_data   = d;
      if_a.out_ready = r;
      #1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [7:0]  rv_d;
   logic        rv_v;
   logic        rv_r;
   logic        m_ov;
   logic [15:0] m_od;
   logic        m_irdy;
   logic        m_acc;
   logic        m_take;
   int          win_q[$];
   int          s;
   logic [7:0]  b_samples [4];

   initial begin
      n_tests = 0;
      n_fail  = 0;
      if_a.in_valid = 1'b0; if_a.in_data = 8'h00; if_a.out_ready = 1'b0;
      if_b.in_valid = 1'b0; if_b.in_data = 8'h00; if_b.out_ready = 1'b0;
      if_c.in_valid = 1'b0; if_c.in_data = 8'h00; if_c.out_ready = 1'b0;
      rst = 1'b1;

      //                v     d      rdy   irdy  ov    od
      tbl[0]  = '{1'b1, 8'h0B, 1'b1, 1'b1, 1'b0, 16'h0000};
      tbl[1]  = '{1'b1, 8'h0B, 1'b1, 1'b1, 1'b0, 16'h0000};
      tbl[2]  = '{1'b1, 8'h0B, 1'b1, 1'b1, 1'b0, 16'h0000};
      tbl[3]  = '{1'b1, 8'h0B, 1'b1, 1'b1, 1'b1, 16'h002C};
      tbl[4]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 16'h002C};
      tbl[5]  = '{1'b1, 8'h80, 1'b1, 1'b1, 1'b0, 16'h002C};
      tbl[6]  = '{1'b1, 8'h80, 1'b1, 1'b1, 1'b0, 16'h002C};
      tbl[7]  = '{1'b1, 8'h80, 1'b1, 1'b1, 1'b0, 16'h002C};
      tbl[8]  = '{1'b1, 8'h80, 1'b1, 1'b1, 1'b1, 16'hFE00};
      tbl[9]  = '{1'b1, 8'h7F, 1'b1, 1'b1, 1'b0, 16'hFE00};
      tbl[10] = '{1'b1, 8'hFF, 1'b1, 1'b1, 1'b0, 16'hFE00};
      tbl[11] = '{1'b1, 8'h05, 1'b1, 1'b1, 1'b0, 16'hFE00};
      tbl[12] = '{1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 16'h0083};
      tbl[13] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 16'h0083};
      tbl[14] = '{1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 16'h0083};
      tbl[15] = '{1'b1, 8'h02, 1'b0, 1'b1, 1'b0, 16'h0083};
      tbl[16] = '{1'b1, 8'h03, 1'b0, 1'b1, 1'b0, 16'h0083};
      tbl[17] = '{1'b1, 8'h04, 1'b0, 1'b1, 1'b1, 16'h000A};
      tbl[18] = '{1'b1, 8'h63, 1'b0, 1'b0, 1'b1, 16'h000A};
      tbl[19] = '{1'b1, 8'h63, 1'b0, 1'b0, 1'b1, 16'h000A};
      tbl[20] = '{1'b1, 8'h63, 1'b0, 1'b0, 1'b1, 16'h000A};
      tbl[21] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 16'h000A};
      tbl[22] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 16'h000A};
      tbl[23] = '{1'b1, 8'h02, 1'b1, 1'b1, 1'b0, 16'h000A};
      tbl[24] = '{1'b0, 8'hAA, 1'b1, 1'b1, 1'b0, 16'h000A};
      tbl[25] = '{1'b0, 8'hAA, 1'b1, 1'b1, 1'b0, 16'h000A};
      tbl[26] = '{1'b1, 8'h05, 1'b1, 1'b1, 1'b0, 16'h000A};
      tbl[27] = '{1'b1, 8'h07, 1'b1, 1'b1, 1'b0, 16'h000A};
      tbl[28] = '{1'b0, 8'hAA, 1'b1, 1'b1, 1'b0, 16'h000A};
      tbl[29] = '{1'b1, 8'h09, 1'b1, 1'b1, 1'b1, 16'h0017};
      tbl[30] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 16'h0017};

      // Reset state on all three builds, with in_valid asserted
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         if_a.in_valid = 1'b1; if_a.in_data = 8'h33; if_a.out_ready = 1'b1;
         if_b.in_valid = 1'b1; if_b.in_data = 8'h33; if_b.out_ready = 1'b1;
         if_c.in_valid = 1'b1; if_c.in_data = 8'h33; if_c.out_ready = 1'b1;
         #1;
         check("rst_irdy_a", 32'(if_a.in_ready), 32'd0);
         check("rst_irdy_b", 32'(if_b.in_ready), 32'd0);
         check("rst_irdy_c", 32'(if_c.in_ready), 32'd0);
         step();
         check("rst_ov_a", 32'(if_a.out_valid), 32'd0);
         check("rst_od_a", 32'(if_a.out_data), 32'd0);
         check("rst_ov_c", 32'(if_c.out_valid), 32'd0);
         check("rst_od_c", 32'(if_c.out_data), 32'd0);
      end
      @(negedge clk);
      rst = 1'b0;
      if_a.in_valid = 1'b0;
      if_b.in_valid = 1'b0;
      if_c.in_valid = 1'b0;

      // Table-driven vectors on the default build
      for (int i = 0; i < 31; i++) begin
         drive_a(tbl[i].v, tbl[i].d, tbl[i].rdy);
         check($sformatf("tbl_irdy[%0d]", i), 32'(if_a.in_ready), 32'(tbl[i].exp_irdy));
         step();
         check($sformatf("tbl_ov[%0d]", i), 32'(if_a.out_valid), 32'(tbl[i].exp_ov));
         check($sformatf("tbl_od[%0d]", i), 32'(if_a.out_data), 32'(tbl[i].exp_od));
      end

      // Reset mid-window: 50 and 60 must be discarded
      drive_a(1'b1, 8'd50, 1'b1); step();
      drive_a(1'b1, 8'd60, 1'b1); step();
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         rst = 1'b1;
         if_a.in_valid = 1'b1; if_a.in_data = 8'd7; if_a.out_ready = 1'b1;
         #1;
         check("midrst_irdy", 32'(if_a.in_ready), 32'd0);
         step();
         check("midrst_ov", 32'(if_a.out_valid), 32'd0);
      end
      @(negedge clk);
      rst = 1'b0;
      if_a.in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive_a(1'b1, 8'd1, 1'b0);
         step();
         check($sformatf("postrst_ov[%0d]", i), 32'(if_a.out_valid), (i == 3) ? 32'd1 : 32'd0);
      end
      check("postrst_od", 32'(if_a.out_data), 32'd4);

      // Reset while holding a sum drops the pending output
      drive_a(1'b0, 8'h00, 1'b0); step();
      check("hold_ov", 32'(if_a.out_valid), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      step();
      check("holdrst_ov", 32'(if_a.out_valid), 32'd0);
      check("holdrst_od", 32'(if_a.out_data), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // 8-bit accumulator wraps: 100+100+0+0 = 200 -> 8'hC8
      b_samples[0] = 8'd100; b_samples[1] = 8'd100; b_samples[2] = 8'd0; b_samples[3] = 8'd0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if_b.in_valid = 1'b1; if_b.in_data = b_samples[i]; if_b.out_ready = 1'b1;
         step();
         check($sformatf("wrap_ov[%0d]", i), 32'(if_b.out_valid), (i == 3) ? 32'd1 : 32'd0);
      end
      check("wrap_od", 32'(if_b.out_data), 32'h0000_00C8);
      @(negedge clk);
      if_b.in_valid = 1'b0;

      // Single-sample window: each sample reappears one cycle later
      @(negedge clk);
      if_c.in_valid = 1'b1; if_c.in_data = 8'hFD; if_c.out_ready = 1'b1;
      step();
      check("w1_ov0", 32'(if_c.out_valid), 32'd1);
      check("w1_od0", 32'(if_c.out_data), 32'h0000_00FD);
      @(negedge clk);
      if_c.in_data = 8'h7F;
      #1;
      check("w1_irdy", 32'(if_c.in_ready), 32'd1);
      step();
      check("w1_ov1", 32'(if_c.out_valid), 32'd1);
      check("w1_od1", 32'(if_c.out_data), 32'h0000_007F);
      @(negedge clk);
      if_c.in_data = 8'h80;
      step();
      check("w1_od2", 32'(if_c.out_data), 32'h0000_0080);
      @(negedge clk);
      if_c.in_valid = 1'b0;
      step();
      check("w1_ov3", 32'(if_c.out_valid), 32'd0);

      // Randomized run against a sample-list model on the default build
      @(negedge clk);
      rst = 1'b1;
      if_a.in_valid = 1'b0;
      step();
      @(negedge clk);
      rst = 1'b0;
      m_ov = 1'b0;
      m_od = 16'h0000;
      win_q.delete();
      for (int i = 0; i < 600; i++) begin
         rv_v = ($urandom_range(0, 3) != 0);
         rv_r = ($urandom_range(0, 2) != 0);
         rv_d = 8'($urandom);
         drive_a(rv_v, rv_d, rv_r);
         m_irdy = !m_ov || rv_r;
         check($sformatf("rand_irdy[%0d]", i), 32'(if_a.in_ready), 32'(m_irdy));
         m_acc  = rv_v && m_irdy;
         m_take = m_ov && rv_r;
         step();
         if (m_take) begin
            m_ov = 1'b0;
         end
         if (m_acc) begin
            win_q.push_back(int'($signed(rv_d)));
            if (win_q.size() == A_WINDOW) begin
               s = 0;
               foreach (win_q[k]) s = s + win_q[k];
               m_od = s[15:0];
               m_ov = 1'b1;
               win_q.delete();
            end
         end
         check($sformatf("rand_ov[%0d]", i), 32'(if_a.out_valid), 32'(m_ov));
         check($sformatf("rand_od[%0d]", i), 32'(if_a.out_data), 32'(m_od));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/acc_window_i8.md
Name: acc_window_i8

Overview:
- Downstream stage of the registered multiply-add unit (y = a*b + c, i8).
- Consumes its signed 8-bit result stream under a valid/ready handshake and accumulates WINDOW consecutive accepted samples.
- Emits one sign-extended window sum per window, held until the consumer takes it.
- Used for dot-product and reduction kernels built from chained muladd DSP stages.

Parameters:
- DATA_W, 8: input sample width, signed two's complement.
- ACC_W, 16: accumulator and output width; must be >= DATA_W.
- WINDOW, 4: samples per sum, >= 1; CNT_W = max(1, clog2(WINDOW)).

Ports:
- clock  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high.
- in_valid  input  1  in_data is valid this cycle.
- in_data  input  DATA_W  signed sample (muladd y output).
- in_ready  output  1  stage accepts a sample this cycle.
- out_valid  output  1  out_data holds a completed window sum.
- out_data  output  ACC_W  signed window sum.
- out_ready  input  1  consumer accepts out_data this cycle.

Behaviour:
- Interface: one clock; reset is synchronous and active-high; ports named clock and reset.
- Reset (sampled at the rising edge):
  - acc = 0, count = 0, state = ACCUM, out_valid = 0, out_data = 0.
  - in_ready reads 0 while reset is high.
- Handshakes:
  - in_ready = !reset && (!out_valid || out_ready), combinational. No in_valid -> in_ready path.
  - Input is accepted when in_valid && in_ready.
  - Output is taken when out_valid && out_ready.
- Arithmetic:
  - in_data is sign-extended to ACC_W before the add.
  - The sum wraps modulo 2^ACC_W. No saturation and no overflow flag.
- States:
  - ACCUM (out_valid = 0): each accepted sample with count < WINDOW-1 does acc <= acc + x, count <= count+1.
  - On the accepted sample where count == WINDOW-1: out_data <= acc + x, out_valid <= 1, acc <= 0, count <= 0, state -> HOLD.
  - HOLD (out_valid = 1): out_data and out_valid are stable while out_ready = 0, and in_ready = 0.
  - On a take, out_valid <= 0 and state -> ACCUM, unless the same cycle also completes a window (possible with out_ready = 1 passthrough). In that case out_data loads the new sum and out_valid stays 1.
- Latency: the sum is visible on out_data the cycle after the last sample of the window is accepted.
- Throughput: with out_ready held at 1, one sample is accepted per cycle with no bubbles.
- Gaps: cycles with in_valid = 0 leave acc and count unchanged. Gaps can be any length.
- WINDOW = 1: every accepted sample is emitted, sign-extended, one cycle later.
- Reset mid-window or mid-HOLD: partial sums and any pending output are discarded. The first window after reset counts only post-reset samples.
- X-safety: acc and out_data never load in_data unless the input is accepted.

Decomposition:
- Shared package acc_pkg:
  - state enum {ACCUM, HOLD}.
  - Functions sext(x, DATA_W -> ACC_W) and clog2 for CNT_W.
  - Default width constants shared with the muladd stage (I8_W = 8).
- No sub-module. Counter, accumulator and output register live in one module, about 150 lines.
- A testbench top may instantiate the muladd unit upstream of this block for end-to-end checks.

Test Plan:
- Four accepted samples of 11 (a=4, b=2, c=3 upstream), out_ready=1 -> out_valid pulses one cycle after the 4th sample, out_data = 44.
- Four samples of -128 -> out_data = 16'hFE00 (-512). Then 127, -1, 5, 0 -> 131.
- Build with ACC_W=8: samples 100, 100, 0, 0 -> out_data = 8'hC8 (wrap, -56). Build with WINDOW=1: sample -3 -> out_data = 8'hFD.
- Backpressure: complete a window of 1,2,3,4 with out_ready=0 for 3 cycles -> out_data = 10 held stable, in_ready = 0, no input consumed. Raise out_ready -> one take, in_ready returns to 1.
- Bubbles: in_valid pattern 1,0,0,1,1,0,1 carrying 2,5,7,9 -> out_data = 23 after the 7th cycle. The count is unaffected by the gaps.
- Reset mid-window: accept 50, 60, then assert reset for 2 cycles, then send 1,1,1,1 -> out_valid = 0 during reset, then out_data = 4.
